// File: rtl/buf_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// buf_pingpong_ctrl
//
// Purpose:
//   Sequencer for the two-bank 8x8 transpose buffer (buf_mem). Incoming
//   64-word blocks arrive row-major on a valid/ready stream. They are written
//   into alternating banks. Each full bank is drained to a valid/ready output
//   stream while the other bank fills. buf_mem maps sequential read addresses
//   column-major, so the output stream is the transposed block. A small skid
//   FIFO absorbs the one-cycle registered read latency of buf_mem, which keeps
//   the output at one word per cycle while the consumer is ready.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       input word valid
//   in_ready   out  1       input word accepted when in_valid && in_ready
//   in_data    in   DATA_W  input coefficient, row-major within block
//   wren       out  1       buf_mem write enable
//   waddr      out  7       buf_mem write address {wr_bank, wcnt}
//   wr_data    out  DATA_W  buf_mem write data (equals in_data)
//   raddr      out  7       buf_mem read address {rd_bank, rcnt}
//   rd_data    in   DATA_W  buf_mem read data, valid one cycle after raddr
//   out_valid  out  1       output word valid
//   out_ready  in   1       output consumer ready
//   out_data   out  DATA_W  transposed coefficient
//   out_last   out  1       marks the 64th word of each output block
//   busy       out  1       any bank full, read in flight, or FIFO non-empty
// -----------------------------------------------------------------------------
module buf_pingpong_ctrl #(
  parameter int DATA_W     = 12,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wren,
  output logic [6:0]        waddr,
  output logic [DATA_W-1:0] wr_data,
  output logic [6:0]        raddr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  localparam logic [5:0]       LAST_IDX   = 6'd63;
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W:0]   OCC_LIMIT  = (CNT_W + 1)'(SKID_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              r_wr_bank;
  logic [5:0]        r_wcnt;
  logic              r_rd_bank;
  logic [5:0]        r_rcnt;
  logic [6:0]        r_raddr;

  // Read tag pipe: the issue cycle is stage 0 (combinational), this register
  // is stage 1 and lines up with rd_data coming back from buf_mem.
  logic              r_tag_vld;
  logic              r_tag_last;

  // Skid FIFO
  logic [DATA_W-1:0] r_fifo_data [SKID_DEPTH];
  logic              r_fifo_last [SKID_DEPTH];
  logic [PTR_W-1:0]  r_fifo_wptr;
  logic [PTR_W-1:0]  r_fifo_rptr;
  logic [CNT_W-1:0]  r_fifo_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [1:0]        w_full;
  logic              w_wr_fire;
  logic              w_wr_done;
  logic              w_rd_issue;
  logic              w_rd_done;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_nonempty;
  logic [CNT_W:0]    w_occupancy;

  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_done = w_wr_fire && (r_wcnt == LAST_IDX);

  // Words already in the FIFO plus the read still in flight must leave room
  // for the word about to be requested, so a push can never overflow.
  assign w_occupancy = {1'b0, r_fifo_count} + {{CNT_W{1'b0}}, r_tag_vld};
  assign w_rd_issue  = !rst && w_full[r_rd_bank] && (w_occupancy < OCC_LIMIT);
  assign w_rd_done   = w_rd_issue && (r_rcnt == LAST_IDX);

  assign w_fifo_nonempty = (r_fifo_count != '0);
  assign w_push          = r_tag_vld;
  assign w_pop           = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Per-bank full flags. A bank is set by the writer's 64th word and cleared
  // by the reader's 64th issue. Set and clear of the same bank cannot coincide
  // (writer needs it empty, reader needs it full); different banks can both
  // change in one cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic r_full_bank;
    logic w_set;
    logic w_clr;

    assign w_set = w_wr_done && (r_wr_bank == 1'(gi));
    assign w_clr = w_rd_done && (r_rd_bank == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_full_bank <= 1'b0;
      end else if (w_set) begin
        r_full_bank <= 1'b1;
      end else if (w_clr) begin
        r_full_bank <= 1'b0;
      end
    end

    assign w_full[gi] = r_full_bank;
  end

  // ---------------------------------------------------------------------------
  // Write side counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wcnt    <= 6'd0;
    end else if (w_wr_fire) begin
      r_wcnt <= r_wcnt + 6'd1;
      if (r_wcnt == LAST_IDX) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side counters and tag pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_rcnt    <= 6'd0;
      r_raddr   <= 7'd0;
    end else if (w_rd_issue) begin
      r_raddr <= {r_rd_bank, r_rcnt};
      r_rcnt  <= r_rcnt + 6'd1;
      // The bank is released on its final issue: the read of the last word is
      // already registered inside buf_mem, so the writer may reuse the bank
      // from the next cycle.
      if (r_rcnt == LAST_IDX) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld  <= 1'b0;
      r_tag_last <= 1'b0;
    end else begin
      r_tag_vld  <= w_rd_issue;
      r_tag_last <= w_rd_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO storage (no reset; contents are masked while empty)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_fifo_wptr] <= rd_data;
      r_fifo_last[r_fifo_wptr] <= r_tag_last;
    end
  end

  // Pointers wrap explicitly so a non power-of-two depth also works.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_wptr  <= '0;
      r_fifo_rptr  <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_wptr <= (r_fifo_wptr == PTR_LAST) ? '0 : r_fifo_wptr + 1'b1;
      end
      if (w_pop) begin
        r_fifo_rptr <= (r_fifo_rptr == PTR_LAST) ? '0 : r_fifo_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
        2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything visible is forced idle while rst is high, including
  // the first reset cycle before the registers have been cleared.
  // ---------------------------------------------------------------------------
  assign in_ready  = !rst && !w_full[r_wr_bank];
  assign wren      = w_wr_fire;
  assign waddr     = rst ? 7'd0 : {r_wr_bank, r_wcnt};
  assign wr_data   = in_data;

  // raddr is live during the issue cycle and otherwise holds the last address.
  assign raddr     = rst ? 7'd0 : (w_rd_issue ? {r_rd_bank, r_rcnt} : r_raddr);

  assign out_valid = !rst && w_fifo_nonempty;
  assign out_data  = out_valid ? r_fifo_data[r_fifo_rptr] : '0;
  assign out_last  = out_valid && r_fifo_last[r_fifo_rptr];

  assign busy      = !rst && ((|w_full) || r_tag_vld || w_fifo_nonempty);

endmodule
